// File: rtl/bcd_seq_converter_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter and display blocks.
package bcd_seq_converter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam logic [3:0] ADD3_THRESH = 4'd5;

    // True when DIGITS decimal digits can hold the largest WIDTH-bit value.
    function automatic bit digits_ok(input int width, input int digits);
        longint pow10;
        longint max_bin;
        pow10 = 1;
        for (int i = 0; i < digits; i++) begin
            pow10 = pow10 * 10;
        end
        max_bin = (longint'(1) << width) - 1;
        return pow10 > max_bin;
    endfunction

endpackage

// File: rtl/bcd_seq_converter_add3_corr.sv
// Single BCD digit corrector for double dabble: values of 5 and above get +3.
module bcd_add3_corr
    import bcd_seq_converter_pkg::*;
(
    input  logic [3:0] d,
    output logic [3:0] q
);

    assign q = (d >= ADD3_THRESH) ? (d + 4'd3) : d;

endmodule

// File: rtl/bcd_seq_converter.sv
// Sequential binary-to-BCD converter, one bit per cycle, valid/ready on both sides.
// Optional leading-zero blanking output enabled by BCD_LEADZERO_BLANK_EN.
//
// state    | meaning
// ST_IDLE  | waiting for in_valid, in_ready=1
// ST_SHIFT | correcting and shifting one bit per cycle
// ST_DONE  | result held until out_ready
module bcd_seq_converter
    import bcd_seq_converter_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    bin,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4*DIGITS-1:0] bcd,
`ifdef BCD_LEADZERO_BLANK_EN
    output logic [DIGITS-1:0]   blank,
`endif
    output logic                busy
);

    localparam int BW = 4 * DIGITS;
    localparam int SW = BW + WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    if (WIDTH < 2 || !digits_ok(WIDTH, DIGITS)) begin : g_param_check
        $error("bcd_seq_converter: DIGITS=%0d too small for WIDTH=%0d", DIGITS, WIDTH);
    end

    state_e          state_q, state_d;
    logic [SW-1:0]   sreg_q, sreg_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [BW-1:0]   bcd_q, bcd_d;
    logic            out_valid_q, out_valid_d;
    logic [BW-1:0]   corr_digits;
    logic [SW-1:0]   shifted;

    for (genvar i = 0; i < DIGITS; i++) begin : g_corr
        bcd_add3_corr u_corr (
            .d (sreg_q[WIDTH + 4*i +: 4]),
            .q (corr_digits[4*i +: 4])
        );
    end

    assign shifted = {corr_digits, sreg_q[WIDTH-1:0]} << 1;

    always_comb begin
        state_d     = state_q;
        sreg_d      = sreg_q;
        cnt_d       = cnt_q;
        bcd_d       = bcd_q;
        out_valid_d = out_valid_q;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    sreg_d  = {{BW{1'b0}}, bin};
                    cnt_d   = CW'(WIDTH);
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                sreg_d = shifted;
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    bcd_d       = shifted[SW-1 -: BW];
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            sreg_q      <= '0;
            cnt_q       <= '0;
            bcd_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sreg_q      <= sreg_d;
            cnt_q       <= cnt_d;
            bcd_q       <= bcd_d;
            out_valid_q <= out_valid_d;
        end
    end

`ifdef BCD_LEADZERO_BLANK_EN
    logic [DIGITS-1:0] blank_q, blank_d;
    logic              higher_zero;

    // blank[0] stays 0 so a zero result still shows one digit.
    always_comb begin
        blank_d     = '0;
        higher_zero = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            higher_zero = higher_zero & (bcd_d[4*i +: 4] == 4'd0);
            blank_d[i]  = higher_zero;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            blank_q <= '0;
        end else if (state_q == ST_SHIFT && cnt_q == CW'(1)) begin
            blank_q <= blank_d;
        end
    end

    assign blank = blank_q;
`endif

    assign bcd       = bcd_q;
    assign out_valid = out_valid_q;
    assign in_ready  = (state_q == ST_IDLE);
    assign busy      = (state_q == ST_SHIFT) || (state_q == ST_DONE);

endmodule

// File: tb/tb_bcd_seq_converter.sv
// Directed plus random bench for bcd_seq_converter against a div/mod decimal model.
module tb_bcd_seq_converter;

    localparam int WIDTH  = 8;
    localparam int DIGITS = 3;

    logic                clk = 1'b0;
    logic                rst;
    logic                in_valid;
    logic                in_ready;
    logic [WIDTH-1:0]    bin;
    logic                out_valid;
    logic                out_ready;
    logic [4*DIGITS-1:0] bcd;
    logic                busy;
`ifdef BCD_LEADZERO_BLANK_EN
    logic [DIGITS-1:0]   blank;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bcd_seq_converter #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bcd       (bcd),
`ifdef BCD_LEADZERO_BLANK_EN
        .blank     (blank),
`endif
        .busy      (busy)
    );

    function automatic logic [31:0] model_bcd(input int n);
        logic [31:0] r;
        int p;
        r = '0;
        p = 1;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'((n / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    // Digit i and everything above it is zero exactly when n < 10**i.
    function automatic logic [31:0] model_blank(input int n);
        logic [31:0] r;
        int p;
        r = '0;
        p = 10;
        for (int i = 1; i < DIGITS; i++) begin
            r[i] = (n < p);
            p = p * 10;
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input int n);
        int k;
        k = 0;
        while (!in_ready && k < 50) begin
            tick();
            k++;
        end
        check("in_ready_wait", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        bin      = WIDTH'(n);
        tick();
        in_valid = 1'b0;
        bin      = WIDTH'($urandom);
    endtask

    // Counts edges after the accept edge until out_valid, then checks the result.
    task automatic finish_conv(input int n, input string tag);
        int lat;
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(WIDTH));
        check({tag, "_bcd"}, 32'(bcd), model_bcd(n));
`ifdef BCD_LEADZERO_BLANK_EN
        check({tag, "_blank"}, 32'(blank), model_blank(n));
`endif
        if (out_ready) begin
            tick();
            check({tag, "_release_ov"}, 32'(out_valid), 32'd0);
            check({tag, "_release_bcd"}, 32'(bcd), model_bcd(n));
        end
    endtask

    task automatic convert(input int n, input string tag);
        accept(n);
        finish_conv(n, tag);
    endtask

    initial begin
        int n;
        int stall;
        rst       = 1'b1;
        in_valid  = 1'b0;
        bin       = '0;
        out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_bcd", 32'(bcd), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
`ifdef BCD_LEADZERO_BLANK_EN
        check("rst_blank", 32'(blank), 32'd0);
`endif

        // Directed values including boundaries.
        convert(255, "v255");
        convert(0, "v0");
        convert(99, "v99");
        convert(100, "v100");
        convert(7, "v7");
        convert(205, "v205");

        // Back-pressure: result must hold while out_ready is low.
        out_ready = 1'b0;
        convert(173, "bp");
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_hold_bcd", 32'(bcd), model_bcd(173));
            check("bp_hold_ov", 32'(out_valid), 32'd1);
            check("bp_hold_in_ready", 32'(in_ready), 32'd0);
            check("bp_hold_busy", 32'(busy), 32'd1);
        end
        out_ready = 1'b1;
        tick();
        check("bp_release_ov", 32'(out_valid), 32'd0);
        check("bp_release_in_ready", 32'(in_ready), 32'd1);

        // in_valid pulse mid-conversion must be ignored.
        accept(7);
        tick();
        tick();
        check("busy_mid_shift", 32'(busy), 32'd1);
        check("in_ready_mid_shift", 32'(in_ready), 32'd0);
        in_valid = 1'b1;
        bin      = 8'd42;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < WIDTH - 3 && !out_valid; i++) tick();
        check("ignore_bcd", 32'(bcd), model_bcd(7));
        check("ignore_ov", 32'(out_valid), 32'd1);
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            check("ignore_no_accept", 32'(busy), 32'd0);
        end

        // Reset in the middle of a conversion aborts it.
        accept(99);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_ov", 32'(out_valid), 32'd0);
        check("abort_bcd", 32'(bcd), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < WIDTH + 2; i++) tick();
        check("abort_no_result", 32'(out_valid), 32'd0);
        convert(200, "after_abort");

        // Random values with random consumer stalls.
        for (int t = 0; t < 40; t++) begin
            n     = int'($urandom_range(0, 255));
            stall = int'($urandom_range(0, 3));
            out_ready = (stall == 0);
            convert(n, "rand");
            if (stall != 0) begin
                for (int i = 0; i < stall; i++) tick();
                check("rand_stall_bcd", 32'(bcd), model_bcd(n));
                check("rand_stall_ov", 32'(out_valid), 32'd1);
                out_ready = 1'b1;
                tick();
                check("rand_stall_release", 32'(out_valid), 32'd0);
            end
        end

        // Exhaustive sweep.
        out_ready = 1'b1;
        for (int v = 0; v < 256; v++) begin
            convert(v, "sweep");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
